grf_wport_arbiter: RTL and testbench
====================================

Name: grf_wport_arbiter

Overview:
- Shares the single GRF write port between W-stage writeback and a late-result requester (multi-cycle MDU/coprocessor result delivering a GPR value).
- W stage always wins the port. Accepted late results are held in a small in-order buffer and drained into idle write cycles.
- Issues a pipeline stall when draining starves.
- Also provides a forwarding lookup so the hazard unit can read pending values.

Parameters:
- DEPTH, 4, late-result buffer entries (power of 2, ≥2)
- STARVE_LIMIT, 8, consecutive non-draining cycles with a non-empty buffer before a stall is forced

Ports:
- Clk  in  1  clock, rising edge
- Rst  in  1  asynchronous active-low reset
- W_RFWr  in  1  W-stage write enable
- W_RFA3  in  5  W-stage destination register
- W_RFWD  in  32  W-stage write data
- Md_Valid  in  1  late-result offered
- Md_A3  in  5  late-result destination
- Md_WD  in  32  late-result data
- Md_Ready  out  1  buffer can accept (handshake completes when Md_Valid & Md_Ready at a rising edge)
- Query_A  in  5  register number looked up by the hazard unit
- Query_Hit  out  1  a live pending entry targets Query_A (never for $0)
- Query_WD  out  32  data of the youngest live matching entry
- GRF_We  out  1  GRF write enable
- GRF_A3  out  5  GRF write address
- GRF_WD  out  32  GRF write data
- Stall_out  out  1  freeze request to the pipeline (D/E/M hold, W receives a bubble)
- Busy_out  out  1  buffer non-empty

Behaviour:
- Reset (Rst=0, async): buffer empty, all valid bits cleared, FSM=IDLE, starve counter=0. Md_Ready=0, Stall_out=0, Busy_out=0, GRF_We=0, Query_Hit=0 while Rst is low.
- Port is "W-owned" when W_RFWr=1 and W_RFA3≠0. In that case GRF_We=1, GRF_A3=W_RFA3, GRF_WD=W_RFWD.
- Port is "free" otherwise.
  - If free and the buffer head is live: GRF_We=1 with the head's A3/WD; the head pops at the edge.
  - If free and the head is dead: it pops with GRF_We=0.
  - If free and the buffer is empty: GRF_We=0.
- Port outputs are combinational from the current inputs and buffer state.
- Md_Ready = !full.
  - Push at the edge when Md_Valid&Md_Ready.
  - Md_A3=0 is accepted and stored as a dead entry.
  - Push and pop in the same cycle when full: Md_Ready stays 0 (Ready is not a function of pop).
  - Push and pop in the same cycle otherwise: both occur and the count is unchanged.
- Supersede rule: a W-owned write to register X in a cycle kills (clears valid) every buffered entry with A3=X. The W instruction is program-order later.
  - An entry pushed in that same cycle with A3=X is not killed.
- Latency: an accepted result reaches the GRF no earlier than the cycle after acceptance.
- Query: combinational search, youngest match wins. Query_A=0 gives Query_Hit=0 and Query_WD=0.
- Pointers wrap modulo DEPTH. The count is log2(DEPTH)+1 bits wide.
- FSM:
  - IDLE: buffer empty. Go to DRAIN on push.
  - DRAIN: non-empty.
    - The starve counter increments on each cycle with no pop and resets on a pop.
    - Go to IDLE when the last entry pops with no push in that cycle.
    - Go to FORCE when the counter reaches STARVE_LIMIT-1 and no pop occurs.
  - FORCE: Stall_out=1.
    - The pipeline inserts bubbles, so the port becomes free next cycle.
    - Go to DRAIN with counter=0 after one pop, or to IDLE if that pop empties the buffer.
- Reset mid-operation: all pending entries are discarded. There is no recovery of lost results.
- Busy_out = count≠0.

Optional Feature:
- Macro: WBARB_BYPASS_EN.
- With the macro: when the buffer is empty, the port is free and Md_Valid=1 with Md_A3≠0, the result writes the GRF in the same cycle. Md_Ready=1, no push, zero latency. Md_A3=0 in this case completes the handshake with GRF_We=0 and no push.
- Without the macro: every late result goes through the buffer, so latency is at least 1 cycle.

Test Plan:
- Port free; push Md_A3=5, WD=0x1234 -> next cycle GRF_We=1, A3=5, WD=0x1234; Busy_out falls the cycle after. With WBARB_BYPASS_EN: write occurs in the push cycle.
- Push 4 results (A3=1..4) while W writes every cycle -> Md_Ready=0 after the 4th; entries drain in order 1,2,3,4 once W idles.
- Buffer holds A3=7 (0xAA); W writes A3=7 (0xBB) -> entry killed, Query_A=7 gives Query_Hit=0, GRF ends with 0xBB and no later overwrite.
- W writes a non-zero register every cycle with one entry pending -> Stall_out=1 on the cycle after STARVE_LIMIT=8 non-draining cycles; drains in the first free cycle; Stall_out=0 after.
- Push A3=9 (0x11) then A3=9 (0x22) -> Query_A=9 returns Hit=1, WD=0x22; Query_A=0 gives Hit=0.
- Assert Rst=0 mid-drain with 3 entries -> outputs immediately 0, Busy_out=0; after release, Md_Ready=1 and no stale GRF writes.

Source files
------------

// File: rtl/grf_wport_arbiter.sv
// GRF write-port arbiter: W stage owns the port, late results queue in an in-order buffer and drain into idle cycles.
// Optional WBARB_BYPASS_EN: an empty buffer plus a free port lets a late result write the GRF in its offer cycle.
module grf_wport_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        W_RFWr,
    input  logic [4:0]  W_RFA3,
    input  logic [31:0] W_RFWD,
    input  logic        Md_Valid,
    input  logic [4:0]  Md_A3,
    input  logic [31:0] Md_WD,
    output logic        Md_Ready,
    input  logic [4:0]  Query_A,
    output logic        Query_Hit,
    output logic [31:0] Query_WD,
    output logic        GRF_We,
    output logic [4:0]  GRF_A3,
    output logic [31:0] GRF_WD,
    output logic        Stall_out,
    output logic        Busy_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;

    typedef enum logic [1:0] {IDLE, DRAIN, FORCE} state_t;

    logic [DEPTH-1:0]       vld_q, vld_d;
    logic [DEPTH-1:0][4:0]  a3_q, a3_d;
    logic [DEPTH-1:0][31:0] wd_q, wd_d;
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d, qidx;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [SW-1:0]          starve_q, starve_d;
    state_t                 state_q, state_d;

    logic w_own, empty, full, byp, push, pop;

    assign w_own = W_RFWr && (W_RFA3 != 5'd0);
    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));

`ifdef WBARB_BYPASS_EN
    assign byp = Rst && empty && !w_own && Md_Valid;
`else
    assign byp = 1'b0;
`endif

    // Ready depends only on fullness, never on a same-cycle pop.
    assign Md_Ready  = Rst && !full;
    assign push      = Md_Valid && Md_Ready && !byp;
    assign pop       = Rst && !w_own && !empty;
    assign Stall_out = (state_q == FORCE);
    assign Busy_out  = !empty;

    always_comb begin
        GRF_We = 1'b0;
        GRF_A3 = '0;
        GRF_WD = '0;
        if (w_own) begin
            GRF_We = 1'b1;
            GRF_A3 = W_RFA3;
            GRF_WD = W_RFWD;
        end else if (!empty) begin
            GRF_We = vld_q[rptr_q];
            GRF_A3 = a3_q[rptr_q];
            GRF_WD = wd_q[rptr_q];
        end else if (byp) begin
            GRF_We = (Md_A3 != 5'd0);
            GRF_A3 = Md_A3;
            GRF_WD = Md_WD;
        end
        if (!Rst) GRF_We = 1'b0;
    end

    always_comb begin
        vld_d  = vld_q;
        a3_d   = a3_q;
        wd_d   = wd_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        // A W write is program-order younger than anything buffered, so it supersedes.
        if (w_own) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a3_q[i] == W_RFA3) vld_d[i] = 1'b0;
            end
        end
        if (pop) begin
            vld_d[rptr_q] = 1'b0;
            rptr_d        = rptr_q + PW'(1);
        end
        if (push) begin
            vld_d[wptr_q] = (Md_A3 != 5'd0);
            a3_d[wptr_q]  = Md_A3;
            wd_d[wptr_q]  = Md_WD;
            wptr_d        = wptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (push) begin
                    state_d  = DRAIN;
                    starve_d = '0;
                end
            end
            DRAIN: begin
                if (pop) begin
                    starve_d = '0;
                    if (cnt_d == '0) state_d = IDLE;
                end else begin
                    starve_d = starve_q + SW'(1);
                    if (starve_q == SW'(STARVE_LIMIT - 1)) state_d = FORCE;
                end
            end
            FORCE: begin
                if (pop) begin
                    starve_d = '0;
                    state_d  = (cnt_d == '0) ? IDLE : DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Walk oldest to youngest so the last hit is the youngest; popped/killed slots have vld clear.
    always_comb begin
        Query_Hit = 1'b0;
        Query_WD  = '0;
        qidx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            qidx = rptr_q + PW'(i);
            if (Query_A != 5'd0 && vld_q[qidx] && a3_q[qidx] == Query_A) begin
                Query_Hit = 1'b1;
                Query_WD  = wd_q[qidx];
            end
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld_q    <= '0;
            a3_q     <= '0;
            wd_q     <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            state_q  <= IDLE;
        end else begin
            vld_q    <= vld_d;
            a3_q     <= a3_d;
            wd_q     <= wd_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            state_q  <= state_d;
        end
    end
endmodule

// File: tb/tb_grf_wport_arbiter.sv
// Scoreboard bench for grf_wport_arbiter: expected late-result writes queue at drive time, pop on non-W GRF writes.
module tb_grf_wport_arbiter;
    logic        Clk = 1'b0;
    logic        Rst;
    logic        W_RFWr;
    logic [4:0]  W_RFA3;
    logic [31:0] W_RFWD;
    logic        Md_Valid;
    logic [4:0]  Md_A3;
    logic [31:0] Md_WD;
    logic        Md_Ready;
    logic [4:0]  Query_A;
    logic        Query_Hit;
    logic [31:0] Query_WD;
    logic        GRF_We;
    logic [4:0]  GRF_A3;
    logic [31:0] GRF_WD;
    logic        Stall_out;
    logic        Busy_out;

    always #5 Clk = ~Clk;

    grf_wport_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
        .Clk(Clk), .Rst(Rst),
        .W_RFWr(W_RFWr), .W_RFA3(W_RFA3), .W_RFWD(W_RFWD),
        .Md_Valid(Md_Valid), .Md_A3(Md_A3), .Md_WD(Md_WD), .Md_Ready(Md_Ready),
        .Query_A(Query_A), .Query_Hit(Query_Hit), .Query_WD(Query_WD),
        .GRF_We(GRF_We), .GRF_A3(GRF_A3), .GRF_WD(GRF_WD),
        .Stall_out(Stall_out), .Busy_out(Busy_out)
    );

    typedef struct packed { logic [4:0] a3; logic [31:0] wd; } wr_t;
    wr_t exp_q[$];
    wr_t mon_e;
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        n_chk++;
        if (obs !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, req);
        end
    endtask

    task automatic drv(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md);
        W_RFWr = we; W_RFA3 = wa; W_RFWD = wd;
        Md_Valid = mv; Md_A3 = ma; Md_WD = md;
    endtask

    task automatic sb_push(input logic [4:0] a3, input logic [31:0] wd);
        exp_q.push_back('{a3: a3, wd: wd});
    endtask

    task automatic nxt();
        @(posedge Clk);
        #1;
    endtask

    // W-owned cycles must show the W write; any other write must be the next expected late result.
    always @(negedge Clk) begin
        if (Rst === 1'b1) begin
            if (W_RFWr && W_RFA3 != 5'd0)
                chk("w_port", 64'({GRF_We, GRF_A3, GRF_WD}), 64'({1'b1, W_RFA3, W_RFWD}));
            else if (GRF_We) begin
                if (exp_q.size() == 0) chk("spurious_wr", 64'(GRF_We), 64'd0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("drain", 64'({GRF_A3, GRF_WD}), 64'(mon_e));
                end
            end
        end
    end

    initial begin
        Rst = 1'b0;
        Query_A = 5'd3;
        drv(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_we", 64'(GRF_We), 64'd0);
        chk("rst_rdy", 64'(Md_Ready), 64'd0);
        chk("rst_busy", 64'(Busy_out), 64'd0);
        chk("rst_stall", 64'(Stall_out), 64'd0);
        chk("rst_hit", 64'(Query_Hit), 64'd0);
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Query_A = 5'd0;
        Rst = 1'b1;
        nxt();

        // single late result on a free port
        drv(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'h1234);
        sb_push(5'd5, 32'h1234);
        @(negedge Clk);
        chk("t1_rdy", 64'(Md_Ready), 64'd1);
        chk("t1_busyA", 64'(Busy_out), 64'd0);
`ifdef WBARB_BYPASS_EN
        chk("t1_weA", 64'(GRF_We), 64'd1);
`else
        chk("t1_weA", 64'(GRF_We), 64'd0);
`endif
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge Clk);
`ifdef WBARB_BYPASS_EN
        chk("t1_busyB", 64'(Busy_out), 64'd0);
`else
        chk("t1_busyB", 64'(Busy_out), 64'd1);
`endif
        nxt();
        @(negedge Clk);
        chk("t1_busyC", 64'(Busy_out), 64'd0);
        chk("t1_sb", 64'(exp_q.size()), 64'd0);
        nxt();

        // fill while W owns the port, then drain in order
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 5'(20 + i), 32'h1000 + i, 1'b1, 5'(i), 32'h100 + i);
            sb_push(5'(i), 32'h100 + i);
            @(negedge Clk);
            chk("t2_rdy", 64'(Md_Ready), 64'd1);
            nxt();
        end
        drv(1'b1, 5'd25, 32'h1005, 1'b1, 5'd6, 32'h106);
        @(negedge Clk);
        chk("t2_full", 64'(Md_Ready), 64'd0);
        chk("t2_busy", 64'(Busy_out), 64'd1);
        chk("t2_stall", 64'(Stall_out), 64'd0);
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge Clk);
        chk("t2_rdy_pop", 64'(Md_Ready), 64'd0);
        nxt();
        @(negedge Clk);
        chk("t2_rdy_after", 64'(Md_Ready), 64'd1);
        repeat (3) nxt();
        @(negedge Clk);
        chk("t2_busy_end", 64'(Busy_out), 64'd0);
        chk("t2_sb", 64'(exp_q.size()), 64'd0);
        nxt();

        // supersede: W write to the same register kills the buffered entry
        drv(1'b1, 5'd20, 32'h55, 1'b1, 5'd7, 32'hAA);
        @(negedge Clk);
        nxt();
        drv(1'b1, 5'd7, 32'hBB, 1'b0, 5'd0, 32'd0);
        Query_A = 5'd7;
        @(negedge Clk);
        chk("t3_hit_pre", 64'(Query_Hit), 64'd1);
        chk("t3_wd_pre", 64'(Query_WD), 64'hAA);
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge Clk);
        chk("t3_hit_kill", 64'(Query_Hit), 64'd0);
        chk("t3_dead_we", 64'(GRF_We), 64'd0);
        chk("t3_dead_busy", 64'(Busy_out), 64'd1);
        nxt();
        drv(1'b1, 5'd8, 32'hC1, 1'b1, 5'd8, 32'hC2);
        sb_push(5'd8, 32'hC2);
        Query_A = 5'd8;
        @(negedge Clk);
        chk("t3_busy_empty", 64'(Busy_out), 64'd0);
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge Clk);
        chk("t3_same_hit", 64'(Query_Hit), 64'd1);
        chk("t3_same_wd", 64'(Query_WD), 64'hC2);
        nxt();
        @(negedge Clk);
        chk("t3_sb", 64'(exp_q.size()), 64'd0);
        nxt();

        // starvation forces a stall after 8 non-draining cycles
        drv(1'b1, 5'd20, 32'h20, 1'b1, 5'd12, 32'h77);
        sb_push(5'd12, 32'h77);
        @(negedge Clk);
        nxt();
        for (int k = 1; k <= 8; k++) begin
            drv(1'b1, 5'(20 + k), 32'h2000 + k, 1'b0, 5'd0, 32'd0);
            @(negedge Clk);
            chk("t4_nostall", 64'(Stall_out), 64'd0);
            nxt();
        end
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        @(negedge Clk);
        chk("t4_stall", 64'(Stall_out), 64'd1);
        chk("t4_we", 64'(GRF_We), 64'd1);
        nxt();
        @(negedge Clk);
        chk("t4_stall_off", 64'(Stall_out), 64'd0);
        chk("t4_busy", 64'(Busy_out), 64'd0);
        chk("t4_sb", 64'(exp_q.size()), 64'd0);
        nxt();

        // forwarding: youngest match wins, $0 never hits
        drv(1'b1, 5'd20, 32'h1, 1'b1, 5'd9, 32'h11);
        sb_push(5'd9, 32'h11);
        @(negedge Clk);
        nxt();
        drv(1'b1, 5'd21, 32'h2, 1'b1, 5'd9, 32'h22);
        sb_push(5'd9, 32'h22);
        @(negedge Clk);
        nxt();
        drv(1'b1, 5'd22, 32'h3, 1'b0, 5'd0, 32'd0);
        Query_A = 5'd9;
        @(negedge Clk);
        chk("t5_hit", 64'(Query_Hit), 64'd1);
        chk("t5_wd", 64'(Query_WD), 64'h22);
        nxt();
        drv(1'b1, 5'd23, 32'h4, 1'b0, 5'd0, 32'd0);
        Query_A = 5'd0;
        @(negedge Clk);
        chk("t5_zero_hit", 64'(Query_Hit), 64'd0);
        chk("t5_zero_wd", 64'(Query_WD), 64'd0);
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Query_A = 5'd9;
        repeat (2) nxt();
        @(negedge Clk);
        chk("t5_hit_gone", 64'(Query_Hit), 64'd0);
        chk("t5_sb", 64'(exp_q.size()), 64'd0);
        nxt();

        // reset while draining discards everything
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 5'(20 + i), 32'h3000 + i, 1'b1, 5'(13 + i), 32'h300 + i);
            @(negedge Clk);
            nxt();
        end
        sb_push(5'd13, 32'h300);
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Query_A = 5'd14;
        @(negedge Clk);
        chk("t6_busy_pre", 64'(Busy_out), 64'd1);
        nxt();
        Rst = 1'b0;
        drv(1'b1, 5'd3, 32'h99, 1'b1, 5'd5, 32'h55);
        @(negedge Clk);
        chk("t6_rst_we", 64'(GRF_We), 64'd0);
        chk("t6_rst_rdy", 64'(Md_Ready), 64'd0);
        chk("t6_rst_busy", 64'(Busy_out), 64'd0);
        chk("t6_rst_stall", 64'(Stall_out), 64'd0);
        chk("t6_rst_hit", 64'(Query_Hit), 64'd0);
        nxt();
        drv(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        Rst = 1'b1;
        @(negedge Clk);
        chk("t6_rdy", 64'(Md_Ready), 64'd1);
        chk("t6_busy", 64'(Busy_out), 64'd0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            chk("t6_no_stale", 64'(GRF_We), 64'd0);
            nxt();
        end
        chk("t6_sb", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
